// File: rtl/cdf_div_pkg.sv
// Shared types and sizing for the CDF equalization divider.
// State encoding, default widths, numerator width and iteration count.
package cdf_div_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int OUT_W_DEF  = 8;
   localparam int SCALE_DEF  = 255;
   localparam int NUM_W      = 24;
   localparam int ITER_N     = 24;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_DIVIDE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;
endpackage

// File: rtl/cdf_divider_if.sv
// Start/operand/result bundle between the equalization controller and one divider.
interface cdf_divider_if
   import cdf_div_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OUT_W  = OUT_W_DEF
);
   logic              div_en;
   logic [DATA_W-1:0] cdf_val;
   logic [DATA_W-1:0] cdf_min;
   logic [DATA_W-1:0] num_pixels;
   logic              div_busy;
   logic              div_done;
   logic [OUT_W-1:0]  div_result;
   logic              div_err;

   modport master (
      output div_en, cdf_val, cdf_min, num_pixels,
      input  div_busy, div_done, div_result, div_err
   );

   modport slave (
      input  div_en, cdf_val, cdf_min, num_pixels,
      output div_busy, div_done, div_result, div_err
   );
endinterface

// File: rtl/cdf_div_step.sv
// One restoring-division iteration: shift in a numerator bit, trial-subtract the denominator.
module cdf_div_step
   import cdf_div_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] rem_in,
   input  logic              num_bit,
   input  logic [DATA_W-1:0] den,
   output logic [DATA_W-1:0] rem_out,
   output logic              q_bit
);
   logic [DATA_W:0] shifted;

   assign shifted = {rem_in, num_bit};

   // The remainder is always below den, so the difference fits back into DATA_W bits.
   always_comb begin
      rem_out = shifted[DATA_W-1:0];
      q_bit   = 1'b0;
      if (shifted >= {1'b0, den}) begin
         rem_out = shifted[DATA_W-1:0] - den;
         q_bit   = 1'b1;
      end
   end
endmodule

// File: rtl/cdf_divider.sv
// Histogram-equalization divider: (cdf_val - cdf_min) * SCALE / (num_pixels - cdf_min),
// one quotient bit per cycle, saturated to OUT_W bits, with a divide-by-zero flag.
module cdf_divider
   import cdf_div_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int SCALE  = SCALE_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   cdf_divider_if.slave  bus
);
   logic [1:0]        rst_sync_reg;
   logic              rst_int_n;

   state_t            state_reg, state_next;
   logic [4:0]        cnt_reg;
   logic [DATA_W-1:0] val_reg, min_reg, np_reg;
   logic [NUM_W-1:0]  num_reg;
   logic [DATA_W-1:0] den_reg;
   logic [DATA_W-1:0] rem_reg;
   logic [NUM_W-1:0]  quot_reg;
   logic [OUT_W-1:0]  result_reg;
   logic              err_reg;

   logic              accept;
   logic              last_iter;
   logic [NUM_W-1:0]  num_load;
   logic [DATA_W-1:0] den_load;
   logic              den_zero;
   logic [DATA_W-1:0] rem_step;
   logic              q_bit;
   logic [NUM_W-1:0]  quot_shift;
   logic [OUT_W-1:0]  quot_sat;

   // Reset asserts immediately but releases on a clock edge, one idle cycle later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_reg <= 2'b00;
      else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end
   assign rst_int_n = rst_sync_reg[1];

   assign accept    = bus.div_en && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign last_iter = (cnt_reg == 5'(ITER_N - 1));

   assign num_load = (val_reg < min_reg) ? '0
                   : NUM_W'(NUM_W'(val_reg - min_reg) * NUM_W'(SCALE));
   assign den_load = np_reg - min_reg;
   assign den_zero = (np_reg <= min_reg);

   cdf_div_step #(.DATA_W(DATA_W)) u_step (
      .rem_in  (rem_reg),
      .num_bit (num_reg[NUM_W-1]),
      .den     (den_reg),
      .rem_out (rem_step),
      .q_bit   (q_bit)
   );

   assign quot_shift = {quot_reg[NUM_W-2:0], q_bit};
   assign quot_sat   = (|quot_shift[NUM_W-1:OUT_W]) ? '1 : quot_shift[OUT_W-1:0];

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) state_reg <= ST_IDLE;
      else            state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (accept) state_next = ST_LOAD;
         ST_LOAD:   state_next = den_zero ? ST_DONE : ST_DIVIDE;
         ST_DIVIDE: if (last_iter) state_next = ST_DONE;
         ST_DONE:   if (accept) state_next = ST_LOAD;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         cnt_reg    <= '0;
         val_reg    <= '0;
         min_reg    <= '0;
         np_reg     <= '0;
         num_reg    <= '0;
         den_reg    <= '0;
         rem_reg    <= '0;
         quot_reg   <= '0;
         result_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         if (accept) begin
            val_reg    <= bus.cdf_val;
            min_reg    <= bus.cdf_min;
            np_reg     <= bus.num_pixels;
            result_reg <= '0;
            err_reg    <= 1'b0;
         end
         case (state_reg)
            ST_LOAD: begin
               num_reg  <= num_load;
               den_reg  <= den_load;
               rem_reg  <= '0;
               quot_reg <= '0;
               cnt_reg  <= '0;
               if (den_zero) begin
                  result_reg <= '1;
                  err_reg    <= 1'b1;
               end
            end
            ST_DIVIDE: begin
               rem_reg  <= rem_step;
               num_reg  <= num_reg << 1;
               quot_reg <= quot_shift;
               cnt_reg  <= cnt_reg + 5'd1;
               if (last_iter) begin
                  result_reg <= quot_sat;
                  err_reg    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.div_busy   = (state_reg == ST_LOAD) || (state_reg == ST_DIVIDE);
   assign bus.div_done   = (state_reg == ST_DONE);
   assign bus.div_result = result_reg;
   assign bus.div_err    = err_reg;
endmodule

// File: tb/tb_cdf_divider.sv
// Scoreboard bench for cdf_divider: directed operands, expected result/flag/latency queued at issue.
module tb_cdf_divider;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   cdf_divider_if #(.DATA_W(16), .OUT_W(8)) bus ();

   cdf_divider #(.DATA_W(16), .OUT_W(8), .SCALE(255)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [7:0] res;
      logic       err;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Drive one request; optionally queue its expected response.
   task automatic issue(input logic [15:0] v, input logic [15:0] mn, input logic [15:0] np,
                        input logic push, input logic [7:0] res, input logic err, input int lat);
      exp_t e;
      @(negedge clk);
      bus.cdf_val    = v;
      bus.cdf_min    = mn;
      bus.num_pixels = np;
      bus.div_en     = 1'b1;
      @(posedge clk);
      #1;
      bus.div_en = 1'b0;
      $display("issue cdf_val=%0d cdf_min=%0d num_pixels=%0d accept_cycle=%0d", v, mn, np, cyc);
      if (push) begin
         e.res = res;
         e.err = err;
         e.lat = lat;
         e.acc = cyc;
         sb_q.push_back(e);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout actual=pending%0d required=pending0", sb_q.size());
         sb_q.delete();
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         check("busy_and_done", {31'd0, bus.div_busy & bus.div_done}, 32'd0);
         if (bus.div_done && !prev_done) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done actual=result%0d required=no_done", bus.div_result);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               $display("done result=%0d err=%0d latency=%0d", bus.div_result, bus.div_err, cyc - e.acc);
               check("result", {24'd0, bus.div_result}, {24'd0, e.res});
               check("err", {31'd0, bus.div_err}, {31'd0, e.err});
               check("latency", cyc - e.acc, e.lat);
            end
         end
      end
      prev_done = bus.div_done;
   end

   localparam int NV = 9;
   logic [15:0] v_val [NV] = '{16'd100, 16'd50, 16'd40, 16'd65535, 16'd10, 16'd5, 16'd1000, 16'd255, 16'd256};
   logic [15:0] v_min [NV] = '{16'd0, 16'd50, 16'd50, 16'd0, 16'd10, 16'd20, 16'd100, 16'd0, 16'd0};
   logic [15:0] v_np  [NV] = '{16'd200, 16'd4096, 16'd4096, 16'd1, 16'd10, 16'd10, 16'd5000, 16'd256, 16'd256};
   logic [7:0]  v_res [NV] = '{8'd127, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd46, 8'd254, 8'd255};
   logic        v_err [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   int          v_lat [NV] = '{25, 25, 25, 25, 1, 1, 25, 25, 25};

   initial begin
      reset_n        = 1'b0;
      bus.div_en     = 1'b0;
      bus.cdf_val    = '0;
      bus.cdf_min    = '0;
      bus.num_pixels = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", {31'd0, bus.div_busy}, 32'd0);
      check("rst_done", {31'd0, bus.div_done}, 32'd0);
      check("rst_result", {24'd0, bus.div_result}, 32'd0);
      check("rst_err", {31'd0, bus.div_err}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         issue(v_val[i], v_min[i], v_np[i], 1'b1, v_res[i], v_err[i], v_lat[i]);
         drain();
      end

      // Second request during DIVIDE must be ignored.
      issue(16'd100, 16'd0, 16'd200, 1'b1, 8'd127, 1'b0, 25);
      repeat (6) @(negedge clk);
      bus.cdf_val    = 16'd65535;
      bus.cdf_min    = 16'd0;
      bus.num_pixels = 16'd1;
      bus.div_en     = 1'b1;
      @(posedge clk);
      #1;
      bus.div_en = 1'b0;
      check("ignored_busy", {31'd0, bus.div_busy}, 32'd1);
      drain();

      // Reset mid-division aborts with nothing reported.
      issue(16'd1000, 16'd100, 16'd5000, 1'b0, 8'd0, 1'b0, 0);
      repeat (13) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, bus.div_busy}, 32'd0);
      check("abort_done", {31'd0, bus.div_done}, 32'd0);
      check("abort_result", {24'd0, bus.div_result}, 32'd0);
      check("abort_err", {31'd0, bus.div_err}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      check("post_rst_busy", {31'd0, bus.div_busy}, 32'd0);
      check("post_rst_done", {31'd0, bus.div_done}, 32'd0);

      // Result holds in DONE, then back-to-back restart.
      issue(16'd255, 16'd0, 16'd256, 1'b1, 8'd254, 1'b0, 25);
      drain();
      repeat (10) @(negedge clk);
      #1;
      check("hold_done", {31'd0, bus.div_done}, 32'd1);
      check("hold_result", {24'd0, bus.div_result}, 32'd254);
      issue(16'd100, 16'd0, 16'd200, 1'b1, 8'd127, 1'b0, 25);
      @(negedge clk);
      #1;
      check("restart_done_low", {31'd0, bus.div_done}, 32'd0);
      check("restart_busy", {31'd0, bus.div_busy}, 32'd1);
      drain();

      check("queue_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
